// File: rtl/ff_pipeline.sv
// ff_pipeline -- parameterised shift-register pipeline with enable, clear,
// valid tags, runtime tap select and a saturating fill counter.
//
// Optional feature: define FF_PIPELINE_EDGE_EN to add per-bit rise/fall
// flags on q (q_prev register plus rise/fall ports).
//
// Parameters:
//   WIDTH      data width in bits (>=1)
//   DEPTH      number of register stages (>=1)
//   RESET_VAL  value loaded into every data stage on reset or clear
//
// Ports:
//   clk        clock, all state updates on rising edge
//   rst        asynchronous active-low reset
//   en         shift enable; pipeline advances only when en=1
//   clr        synchronous clear, has priority over en
//   d          data into stage 0
//   d_valid    valid tag travelling with d
//   tap_sel    runtime stage select for tap_q/tap_valid
//   q          data of last stage (DEPTH-1)
//   q_valid    valid tag of last stage
//   tap_q      data of stage tap_sel (RESET_VAL when tap_sel >= DEPTH)
//   tap_valid  valid tag of stage tap_sel (0 when tap_sel >= DEPTH)
//   fill_cnt   enabled shifts since reset/clear, saturating at DEPTH
//   primed     high when fill_cnt == DEPTH
//   rise/fall  (FF_PIPELINE_EDGE_EN only) per-bit edge flags on q
//
// Handshake note: there is no back-pressure. d/d_valid are accepted on every
// rising edge where en=1 and clr=0; d_valid is only a tag carried alongside
// the data, never a request that waits for a ready.
module ff_pipeline #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              TW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int              CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  input  logic [TW-1:0]    tap_sel,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [WIDTH-1:0] tap_q,
  output logic             tap_valid,
  output logic [CW-1:0]    fill_cnt,
`ifdef FF_PIPELINE_EDGE_EN
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
`endif
  output logic             primed
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] stage [DEPTH];
  logic [DEPTH-1:0] vld;

  // Data and valid-tag shift register. Clear wins over enable so a
  // simultaneous clr/en never captures d.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= RESET_VAL;
      end
      vld <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= RESET_VAL;
      end
      vld <= '0;
    end else if (en) begin
      stage[0] <= d;
      vld[0]   <= d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
        vld[i]   <= vld[i-1];
      end
    end
  end

  // Fill counter saturates at DEPTH; it counts enabled shifts, not valid data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_cnt <= '0;
    end else if (clr) begin
      fill_cnt <= '0;
    end else if (en && (fill_cnt != FULL_CNT)) begin
      fill_cnt <= fill_cnt + CW'(1);
    end
  end

  assign primed  = (fill_cnt == FULL_CNT);
  assign q       = stage[DEPTH-1];
  assign q_valid = vld[DEPTH-1];

  // Tap mux. tap_sel can encode values >= DEPTH when DEPTH is not a power of
  // two; those select nothing and leave the reset/invalid defaults.
  always_comb begin
    tap_q     = RESET_VAL;
    tap_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_sel == TW'(i)) begin
        tap_q     = stage[i];
        tap_valid = vld[i];
      end
    end
  end

`ifdef FF_PIPELINE_EDGE_EN
  logic [WIDTH-1:0] q_prev;

  // q_prev follows q on every edge regardless of en/clr, so a stall makes
  // rise/fall drop to zero after one cycle rather than holding the flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_prev <= RESET_VAL;
    end else begin
      q_prev <= q;
    end
  end

  assign rise = q & ~q_prev;
  assign fall = ~q & q_prev;
`endif

endmodule

// File: tb/tb_ff_pipeline.sv
// tb_ff_pipeline -- directed self-checking bench for ff_pipeline.
// Three instances share clock, reset and shift controls:
//   u_d4  WIDTH=8 DEPTH=4  (main function, stall, clear, reset, latency)
//   u_d3  WIDTH=8 DEPTH=3  (tap select including out-of-range select)
//   u_d1  WIDTH=8 DEPTH=1  (single-FF behaviour, edge flags when enabled)
module tb_ff_pipeline;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic       en      = 1'b0;
  logic       clr     = 1'b0;
  logic [7:0] d       = 8'h00;
  logic       d_valid = 1'b0;

  logic [1:0] tap_sel4 = 2'd0;
  logic [1:0] tap_sel3 = 2'd0;
  logic [0:0] tap_sel1 = 1'b0;

  logic [7:0] q4, tap_q4, q3, tap_q3, q1, tap_q1;
  logic       q_valid4, tap_valid4, q_valid3, tap_valid3, q_valid1, tap_valid1;
  logic [2:0] fill_cnt4;
  logic [1:0] fill_cnt3;
  logic [0:0] fill_cnt1;
  logic       primed4, primed3, primed1;
`ifdef FF_PIPELINE_EDGE_EN
  logic [7:0] rise4, fall4, rise3, fall3, rise1, fall1;
`endif

  ff_pipeline #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u_d4 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d), .d_valid(d_valid),
    .tap_sel(tap_sel4), .q(q4), .q_valid(q_valid4), .tap_q(tap_q4),
    .tap_valid(tap_valid4), .fill_cnt(fill_cnt4),
`ifdef FF_PIPELINE_EDGE_EN
    .rise(rise4), .fall(fall4),
`endif
    .primed(primed4)
  );

  ff_pipeline #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) u_d3 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d), .d_valid(d_valid),
    .tap_sel(tap_sel3), .q(q3), .q_valid(q_valid3), .tap_q(tap_q3),
    .tap_valid(tap_valid3), .fill_cnt(fill_cnt3),
`ifdef FF_PIPELINE_EDGE_EN
    .rise(rise3), .fall(fall3),
`endif
    .primed(primed3)
  );

  ff_pipeline #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d), .d_valid(d_valid),
    .tap_sel(tap_sel1), .q(q1), .q_valid(q_valid1), .tap_q(tap_q1),
    .tap_valid(tap_valid1), .fill_cnt(fill_cnt1),
`ifdef FF_PIPELINE_EDGE_EN
    .rise(rise1), .fall(fall1),
`endif
    .primed(primed1)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are changed 1 time unit after a rising edge and outputs are
  // sampled at the same point, well away from the next active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift(input logic [7:0] data, input logic valid);
    en = 1'b1; clr = 1'b0; d = data; d_valid = valid;
    tick();
    en = 1'b0;
  endtask

  task automatic do_clear();
    en = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Latency/stall table: en pattern with distinct data per step.
  localparam int NLAT = 12;
  logic lat_en [NLAT] = '{1,1,0,1,1,0,0,1,1,0,1,1};

  // ---------------- main sequence ----------------
  initial begin
    // Reset state
    #3;
    check("rst_q", q4, 8'h00);
    check("rst_q_valid", q_valid4, 1'b0);
    check("rst_fill_cnt", fill_cnt4, 3'd0);
    check("rst_primed", primed4, 1'b0);
`ifdef FF_PIPELINE_EDGE_EN
    check("rst_rise", rise4, 8'h00);
    check("rst_fall", fall4, 8'h00);
`endif
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Basic fill: 0x11..0x44
    shift(8'h11, 1'b1);
    check("fill_cnt_1", fill_cnt4, 3'd1);
    check("primed_1", primed4, 1'b0);
    shift(8'h22, 1'b1);
    shift(8'h33, 1'b1);
    check("q_before_full", q4, 8'h00);
    check("q_valid_before_full", q_valid4, 1'b0);
    shift(8'h44, 1'b1);
    check("fill_q", q4, 8'h11);
    check("fill_q_valid", q_valid4, 1'b1);
    check("fill_primed", primed4, 1'b1);
    check("fill_cnt_4", fill_cnt4, 3'd4);
    tap_sel4 = 2'd0; #1;
    check("tap0", tap_q4, 8'h44);
    tap_sel4 = 2'd2; #1;
    check("tap2", tap_q4, 8'h22);
    check("tap2_valid", tap_valid4, 1'b1);
    shift(8'h55, 1'b0);
    check("sat_q", q4, 8'h22);
    check("sat_fill_cnt", fill_cnt4, 3'd4);
    check("sat_primed", primed4, 1'b1);
    tap_sel4 = 2'd0; #1;
    check("tap0_invalid_tag", tap_valid4, 1'b0);

    // Stall holds data
    do_clear();
    shift(8'hA1, 1'b1);
    shift(8'hA2, 1'b1);
    shift(8'hA3, 1'b1);
    shift(8'hA4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      en = 1'b0; d = 8'hEE; d_valid = 1'b1;
      tick();
      check("stall_q", q4, 8'hA1);
      check("stall_fill_cnt", fill_cnt4, 3'd4);
    end
    shift(8'hA5, 1'b1);
    check("after_stall_q", q4, 8'hA2);
    check("after_stall_q_valid", q_valid4, 1'b1);

    // Clear beats enable on the same edge
    en = 1'b1; clr = 1'b1; d = 8'h99; d_valid = 1'b1;
    tick();
    en = 1'b0; clr = 1'b0;
    check("clr_q", q4, 8'h00);
    check("clr_q_valid", q_valid4, 1'b0);
    check("clr_fill_cnt", fill_cnt4, 3'd0);
    check("clr_primed", primed4, 1'b0);
    tap_sel4 = 2'd0; #1;
    check("clr_d_not_captured", tap_q4, 8'h00);
    check("clr_tap_valid", tap_valid4, 1'b0);

    // Asynchronous reset mid-cycle while full
    shift(8'hC1, 1'b1);
    shift(8'hC2, 1'b1);
    shift(8'hC3, 1'b1);
    shift(8'hC4, 1'b1);
    check("pre_rst_q", q4, 8'hC1);
    #1 rst = 1'b0;
    #1;
    check("async_rst_q", q4, 8'h00);
    check("async_rst_q_valid", q_valid4, 1'b0);
    check("async_rst_fill_cnt", fill_cnt4, 3'd0);
    check("async_rst_primed", primed4, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    shift(8'h77, 1'b1);
    tap_sel4 = 2'd0; #1;
    check("restart_tap0", tap_q4, 8'h77);
    tap_sel4 = 2'd1; #1;
    check("restart_tap1", tap_q4, 8'h00);
    check("restart_q", q4, 8'h00);
    check("restart_fill_cnt", fill_cnt4, 3'd1);

    // Latency with interleaved stalls, expected-queue scoreboard
    do_clear();
    exp_q.delete();
    for (int i = 0; i < NLAT; i++) begin
      en = lat_en[i]; clr = 1'b0; d = 8'h30 + 8'(i); d_valid = 1'b1;
      if (lat_en[i]) begin
        exp_q.push_back(8'h30 + 8'(i));
        if (exp_q.size() > 4) void'(exp_q.pop_front());
      end
      tick();
      check("lat_q", q4, (exp_q.size() == 4) ? exp_q[0] : 8'h00);
      check("lat_fill_cnt", fill_cnt4, exp_q.size());
    end
    en = 1'b0;

    // DEPTH=3 tap select, including out-of-range select
    do_clear();
    shift(8'h10, 1'b1);
    shift(8'h20, 1'b1);
    shift(8'h30, 1'b1);
    tap_sel3 = 2'd1; #1;
    check("d3_tap1", tap_q3, 8'h20);
    check("d3_tap1_valid", tap_valid3, 1'b1);
    tap_sel3 = 2'd3; #1;
    check("d3_tap3", tap_q3, 8'h00);
    check("d3_tap3_valid", tap_valid3, 1'b0);
    check("d3_q", q3, 8'h10);
    check("d3_primed", primed3, 1'b1);

    // DEPTH=1 single-FF behaviour and edge flags
    do_clear();
    check("d1_clr_primed", primed1, 1'b0);
    shift(8'h00, 1'b1);
    check("d1_q0", q1, 8'h00);
    check("d1_primed", primed1, 1'b1);
    check("d1_fill_cnt", fill_cnt1, 1'b1);
`ifdef FF_PIPELINE_EDGE_EN
    check("d1_rise0", rise1, 8'h00);
`endif
    shift(8'h0F, 1'b1);
    check("d1_q1", q1, 8'h0F);
    check("d1_q_valid", q_valid1, 1'b1);
`ifdef FF_PIPELINE_EDGE_EN
    check("d1_rise1", rise1, 8'h0F);
    check("d1_fall1", fall1, 8'h00);
`endif
    shift(8'h05, 1'b0);
    check("d1_q2", q1, 8'h05);
    check("d1_q_valid2", q_valid1, 1'b0);
`ifdef FF_PIPELINE_EDGE_EN
    check("d1_rise2", rise1, 8'h00);
    check("d1_fall2", fall1, 8'h0A);
    tick();
    check("d1_fall_stall", fall1, 8'h00);
    check("d1_rise_stall", rise1, 8'h00);
`endif
    tick();
    check("d1_hold", q1, 8'h05);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
